act_unit_scheduler: RTL and testbench

- Shares one tanh LUT+linear-interpolation activation unit among NREQ requesters, e.g. the LSTM gate neurons of one layer.
- Each requester presents an 8-bit signed pre-activation over a valid/ready handshake.
- A round-robin arbiter issues at most one operand per cycle into a 2-stage registered wrapper around the activation datapath.
- The result comes back tagged by a one-hot response valid.

---
 rtl/act_unit_scheduler_pkg.sv | 31 +++
 rtl/act_unit_scheduler_if.sv | 35 +++
 rtl/act_unit_scheduler_tanh_lut_interp.sv | 69 ++++++
 rtl/act_unit_scheduler.sv | 121 ++++++++++++
 tb/tb_act_unit_scheduler.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/act_unit_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// act_unit_scheduler_pkg
// Shared constants and types for the shared tanh activation scheduler:
//   WIDTH      operand/result width (signed)
//   ADDR_BITS  LUT address bits taken from the operand MSBs
//   FRAC_BITS  interpolation fraction bits (operand LSBs)
//   CHANGE     operand distance between two neighbouring LUT points
//   operand_t  signed operand/result type
//   tag_t      one-hot requester tag for the default requester count
// -----------------------------------------------------------------------------
package act_unit_scheduler_pkg;

   localparam int WIDTH     = 8;
   localparam int ADDR_BITS = 4;
   localparam int FRAC_BITS = WIDTH - ADDR_BITS;
   localparam int CHANGE    = 1 << FRAC_BITS;
   localparam int NUM_REQ   = 4;

   // Internal width of the interpolation product: 9-bit delta times 5-bit fraction.
   localparam int PROD_W    = WIDTH + FRAC_BITS + 2;

   typedef logic signed [WIDTH-1:0] operand_t;
   typedef logic [NUM_REQ-1:0]      tag_t;

   // Maps the signed address nibble (-8..7) onto table rows 0..15 so that
   // row r+1 is always the next point up the input axis.
   function automatic logic [ADDR_BITS:0] lut_index(input operand_t x);
      lut_index = {1'b0, ~x[WIDTH-1], x[WIDTH-2:FRAC_BITS]};
   endfunction

endpackage

// File: rtl/act_unit_scheduler_if.sv
// -----------------------------------------------------------------------------
// act_unit_scheduler_if
// Requester/response bundle of the shared activation scheduler.
//   req_valid  per-requester operand valid
//   req_data   flat operand bus, requester i at [i*WIDTH +: WIDTH]
//   req_ready  one-hot grant
//   rsp_valid  one-hot 1-cycle response pulse
//   rsp_data   signed activation result
//   busy       pipeline holds at least one entry
// master: requester side, slave: scheduler side.
// -----------------------------------------------------------------------------
interface act_unit_scheduler_if
   import act_unit_scheduler_pkg::*;
#(
   parameter int NREQ = NUM_REQ
) ();

   logic [NREQ-1:0]       req_valid;
   logic [NREQ*WIDTH-1:0] req_data;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ-1:0]       rsp_valid;
   operand_t              rsp_data;
   logic                  busy;

   modport master (
      output req_valid, req_data,
      input  req_ready, rsp_valid, rsp_data, busy
   );

   modport slave (
      input  req_valid, req_data,
      output req_ready, rsp_valid, rsp_data, busy
   );

endinterface

// File: rtl/act_unit_scheduler_tanh_lut_interp.sv
// -----------------------------------------------------------------------------
// tanh_lut_interp
// Combinational tanh approximation: 17-point table of round(127*tanh(v)) at
// v = -4.0, -3.5, ..., +4.0 (operand scale 1/32), linear interpolation between
// neighbouring points, result saturated to the signed WIDTH range.
//   x  in   signed operand
//   y  out  signed activation
// -----------------------------------------------------------------------------
module tanh_lut_interp
   import act_unit_scheduler_pkg::*;
(
   input  operand_t x,
   output operand_t y
);

   localparam logic signed [PROD_W-1:0] SAT_HI = {{(PROD_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic signed [PROD_W-1:0] SAT_LO = {{(PROD_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

   function automatic operand_t lut_point(input logic [ADDR_BITS:0] idx);
      case (idx)
         5'd0:    lut_point = -8'sd127;
         5'd1:    lut_point = -8'sd127;
         5'd2:    lut_point = -8'sd126;
         5'd3:    lut_point = -8'sd125;
         5'd4:    lut_point = -8'sd122;
         5'd5:    lut_point = -8'sd115;
         5'd6:    lut_point = -8'sd97;
         5'd7:    lut_point = -8'sd59;
         5'd8:    lut_point =  8'sd0;
         5'd9:    lut_point =  8'sd59;
         5'd10:   lut_point =  8'sd97;
         5'd11:   lut_point =  8'sd115;
         5'd12:   lut_point =  8'sd122;
         5'd13:   lut_point =  8'sd125;
         5'd14:   lut_point =  8'sd126;
         5'd15:   lut_point =  8'sd127;
         5'd16:   lut_point =  8'sd127;
         default: lut_point =  8'sd0;
      endcase
   endfunction

   logic [ADDR_BITS:0]        idx_s;
   operand_t                  base_s;
   operand_t                  next_s;
   logic signed [PROD_W-1:0]  delta_s;
   logic signed [PROD_W-1:0]  frac_s;
   logic signed [PROD_W-1:0]  prod_s;
   logic signed [PROD_W-1:0]  sum_s;

   // Table lookup, interpolation over CHANGE operand steps, then saturation.
   always_comb begin
      idx_s   = lut_index(x);
      base_s  = lut_point(idx_s);
      next_s  = lut_point(idx_s + 5'd1);
      delta_s = {{(PROD_W-WIDTH){next_s[WIDTH-1]}}, next_s}
              - {{(PROD_W-WIDTH){base_s[WIDTH-1]}}, base_s};
      frac_s  = {{(PROD_W-FRAC_BITS){1'b0}}, x[FRAC_BITS-1:0]};
      prod_s  = delta_s * frac_s;
      sum_s   = {{(PROD_W-WIDTH){base_s[WIDTH-1]}}, base_s} + (prod_s >>> FRAC_BITS);
      if (sum_s > SAT_HI) begin
         y = SAT_HI[WIDTH-1:0];
      end else if (sum_s < SAT_LO) begin
         y = SAT_LO[WIDTH-1:0];
      end else begin
         y = sum_s[WIDTH-1:0];
      end
   end

endmodule

// File: rtl/act_unit_scheduler.sv
// -----------------------------------------------------------------------------
// act_unit_scheduler
// Round-robin sharing of one tanh LUT+interpolation unit among NREQ requesters.
// One operand per cycle enters a 2-stage pipeline; the result returns exactly
// two cycles after the handshake, tagged with a one-hot rsp_valid.
//   clk   clock, rising edge
//   rst   synchronous active-high reset
//   bus   slave side of act_unit_scheduler_if (req_*, rsp_*, busy)
// -----------------------------------------------------------------------------
module act_unit_scheduler
   import act_unit_scheduler_pkg::*;
#(
   parameter int NREQ = NUM_REQ
) (
   input  logic                 clk,
   input  logic                 rst,
   act_unit_scheduler_if.slave  bus
);

   localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [PTR_W-1:0] rr_ptr_r;
   logic             s1_valid_r;
   logic [NREQ-1:0]  s1_tag_r;
   operand_t         s1_data_r;
   logic [NREQ-1:0]  rsp_valid_r;
   operand_t         rsp_data_r;
   logic             busy_r;

   logic [PTR_W:0]   sum_s;
   logic [PTR_W-1:0] cand_s;
   logic             hit_s;
   logic             grant_any_s;
   logic [PTR_W-1:0] grant_idx_s;
   logic [PTR_W-1:0] next_ptr_s;
   logic [NREQ-1:0]  grant_s;
   logic             hs_s;
   operand_t         grant_data_s;
   operand_t         act_s;

   // Round-robin select: first valid requester at or after rr_ptr, wrapping.
   always_comb begin
      sum_s        = '0;
      cand_s       = '0;
      hit_s        = 1'b0;
      grant_any_s  = 1'b0;
      grant_idx_s  = '0;
      grant_data_s = '0;
      for (int k = 0; k < NREQ; k++) begin
         sum_s = {1'b0, rr_ptr_r} + (PTR_W+1)'(k);
         if (sum_s >= (PTR_W+1)'(NREQ)) begin
            cand_s = PTR_W'(sum_s - (PTR_W+1)'(NREQ));
         end else begin
            cand_s = sum_s[PTR_W-1:0];
         end
         hit_s       = ~grant_any_s & bus.req_valid[cand_s];
         grant_idx_s = hit_s ? cand_s : grant_idx_s;
         grant_any_s = grant_any_s | hit_s;
      end
      for (int k = 0; k < NREQ; k++) begin
         grant_data_s = (PTR_W'(k) == grant_idx_s) ? operand_t'(bus.req_data[k*WIDTH +: WIDTH])
                                                   : grant_data_s;
      end
      // Grants are suppressed while reset is held.
      hs_s    = grant_any_s & ~rst;
      grant_s = '0;
      if (hs_s) begin
         grant_s[grant_idx_s] = 1'b1;
      end else begin
         grant_s = '0;
      end
      if (grant_idx_s == PTR_W'(NREQ-1)) begin
         next_ptr_s = '0;
      end else begin
         next_ptr_s = grant_idx_s + PTR_W'(1);
      end
   end

   tanh_lut_interp u_act (
      .x (s1_data_r),
      .y (act_s)
   );

   // Pointer update, stage-1 capture and stage-2 (response) registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_r    <= '0;
         s1_valid_r  <= 1'b0;
         s1_tag_r    <= '0;
         s1_data_r   <= '0;
         rsp_valid_r <= '0;
         rsp_data_r  <= '0;
         busy_r      <= 1'b0;
      end else begin
         if (hs_s) begin
            rr_ptr_r   <= next_ptr_s;
            s1_data_r  <= grant_data_s;
            s1_tag_r   <= grant_s;
            s1_valid_r <= 1'b1;
         end else begin
            s1_valid_r <= 1'b0;
         end
         // Stage 2 is the response register itself; the tag is gated by
         // stage-1 valid so rsp_valid is a one-cycle pulse.
         rsp_valid_r <= s1_valid_r ? s1_tag_r : '0;
         if (s1_valid_r) begin
            rsp_data_r <= act_s;
         end else begin
            rsp_data_r <= rsp_data_r;
         end
         // Next-cycle occupancy: new stage-1 entry or stage-1 moving to stage 2.
         busy_r <= hs_s | s1_valid_r;
      end
   end

   assign bus.req_ready = grant_s;
   assign bus.rsp_valid = rsp_valid_r;
   assign bus.rsp_data  = rsp_data_r;
   assign bus.busy      = busy_r;

endmodule

// File: tb/tb_act_unit_scheduler.sv
// -----------------------------------------------------------------------------
// tb_act_unit_scheduler
// Directed stimulus; a transaction-level model (grant scan, queue of due
// responses, tanh sample table) is compared against the DUT every cycle on
// the falling edge, plus literal expectations for each scenario.
// -----------------------------------------------------------------------------
module tb_act_unit_scheduler;
   import act_unit_scheduler_pkg::*;

   localparam int N = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   act_unit_scheduler_if #(.NREQ(N)) bus_if ();

   act_unit_scheduler #(.NREQ(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // round(127*tanh(v)) for v = -4.0 .. +4.0 in steps of 0.5 (operand/32)
   int pts [0:16] = '{-127, -127, -126, -125, -122, -115, -97, -59, 0,
                      59, 97, 115, 122, 125, 126, 127, 127};

   function automatic int act_model(input int x);
      int pos, seg, frac, v;
      pos  = x + 128;          // distance from -4.0 in operand units
      seg  = pos / 16;
      frac = pos % 16;
      v    = pts[seg] + ((pts[seg+1] - pts[seg]) * frac) / 16;
      if (v > 127) v = 127;
      if (v < -128) v = -128;
      return v;
   endfunction

   function automatic int onehot_idx(input logic [N-1:0] v);
      int r;
      r = -1;
      for (int i = 0; i < N; i++) if (v[i]) r = i;
      return r;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   typedef struct {
      int due;
      int idx;
      int res;
   } ent_t;

   ent_t q[$];
   int   cyc = 0;
   int   m_ptr = 0;
   int   m_last = 0;
   int   busy_cnt = 0;
   int   grant_log[$];
   int   rsp_idx_log[$];
   int   rsp_res_log[$];

   // Per-cycle comparison against the transaction model, then model advance.
   always @(negedge clk) begin : model_cmp
      int g, c, e_rdy, e_rv, e_rd, e_busy;
      logic signed [7:0] d;
      ent_t e;
      g = -1;
      if (!rst) begin
         for (int k = 0; k < N; k++) begin
            c = (m_ptr + k) % N;
            if (g < 0 && bus_if.req_valid[c]) g = c;
         end
      end
      e_rdy  = (g < 0) ? 0 : (1 << g);
      e_rv   = 0;
      e_rd   = m_last;
      if (q.size() > 0 && q[0].due == cyc) begin
         e_rv = 1 << q[0].idx;
         e_rd = q[0].res;
      end
      e_busy = (q.size() > 0) ? 1 : 0;
      chk("req_ready", int'(bus_if.req_ready), e_rdy);
      chk("rsp_valid", int'(bus_if.rsp_valid), e_rv);
      chk("rsp_data",  int'(bus_if.rsp_data),  e_rd);
      chk("busy",      int'(bus_if.busy),      e_busy);
      if (bus_if.req_ready != '0) grant_log.push_back(onehot_idx(bus_if.req_ready));
      if (bus_if.rsp_valid != '0) begin
         rsp_idx_log.push_back(onehot_idx(bus_if.rsp_valid));
         rsp_res_log.push_back(int'(bus_if.rsp_data));
      end
      if (bus_if.busy) busy_cnt++;
      if (rst) begin
         q.delete();
         m_ptr  = 0;
         m_last = 0;
      end else begin
         if (q.size() > 0 && q[0].due == cyc) begin
            m_last = q[0].res;
            void'(q.pop_front());
         end
         if (g >= 0) begin
            d     = bus_if.req_data[g*8 +: 8];
            e.due = cyc + 2;
            e.idx = g;
            e.res = act_model(int'(d));
            q.push_back(e);
            m_ptr = (g + 1) % N;
         end
      end
      cyc++;
   end

   task automatic drive(input logic r, input logic [3:0] v,
                        input logic [7:0] d3, input logic [7:0] d2,
                        input logic [7:0] d1, input logic [7:0] d0);
      @(posedge clk);
      #2;
      rst              = r;
      bus_if.req_valid = v;
      bus_if.req_data  = {d3, d2, d1, d0};
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
   endtask

   task automatic clear_logs();
      grant_log.delete();
      rsp_idx_log.delete();
      rsp_res_log.delete();
      busy_cnt = 0;
   endtask

   int exp_res [0:3] = '{59, 29, -30, 122};
   int tag1_res [$];

   initial begin
      bus_if.req_valid = '0;
      bus_if.req_data  = '0;

      // model pins
      chk("model_0x00", act_model(0), 0);
      chk("model_0x7F", act_model(127), 127);
      chk("model_0x80", act_model(-128), -127);
      chk("model_0x40", act_model(64), 122);
      chk("model_0x08", act_model(8), 29);
      chk("model_0xF8", act_model(-8), -30);

      drive(1'b1, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
      drive(1'b1, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);

      // single request from requester 0
      clear_logs();
      drive(1'b0, 4'b0001, 8'h00, 8'h00, 8'h00, 8'h00);
      #1;
      chk("t1_ready_same_cycle", int'(bus_if.req_ready), 1);
      idle(5);
      chk("t1_grants", grant_log.size(), 1);
      chk("t1_rsps", rsp_idx_log.size(), 1);
      if (rsp_idx_log.size() == 1) begin
         chk("t1_rsp_idx", rsp_idx_log[0], 0);
         chk("t1_rsp_data", rsp_res_log[0], 0);
      end
      chk("t1_busy_cycles", busy_cnt, 2);

      // all four continuously for 8 cycles
      drive(1'b1, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
      clear_logs();
      for (int i = 0; i < 8; i++) drive(1'b0, 4'b1111, 8'h40, 8'hF8, 8'h08, 8'h10);
      idle(5);
      chk("t2_grants", grant_log.size(), 8);
      chk("t2_rsps", rsp_idx_log.size(), 8);
      for (int i = 0; i < 8; i++) begin
         if (i < grant_log.size()) chk("t2_grant_order", grant_log[i], i % 4);
         if (i < rsp_idx_log.size()) begin
            chk("t2_rsp_order", rsp_idx_log[i], i % 4);
            chk("t2_rsp_data", rsp_res_log[i], exp_res[i % 4]);
         end
      end

      // full operand sweep through requester 2, back-to-back
      clear_logs();
      for (int x = -128; x < 128; x++) drive(1'b0, 4'b0100, 8'h00, 8'(x), 8'h00, 8'h00);
      idle(5);
      chk("t3_rsps", rsp_idx_log.size(), 256);
      chk("t3_busy_cycles", busy_cnt, 257);
      if (rsp_res_log.size() == 256) begin
         chk("t3_min_operand", rsp_res_log[0], -127);
         chk("t3_zero_operand", rsp_res_log[128], 0);
         chk("t3_max_operand", rsp_res_log[255], 127);
         for (int i = 0; i < 256; i++) begin
            if (rsp_idx_log[i] != 2) chk("t3_tag", rsp_idx_log[i], 2);
         end
      end

      // sparse contention, rr_ptr at 3 after the sweep
      clear_logs();
      drive(1'b0, 4'b0101, 8'h00, 8'h30, 8'h00, 8'h20);
      drive(1'b0, 4'b0101, 8'h00, 8'h30, 8'h00, 8'h20);
      drive(1'b0, 4'b1001, 8'h50, 8'h00, 8'h00, 8'h20);
      drive(1'b0, 4'b1001, 8'h50, 8'h00, 8'h00, 8'h20);
      idle(5);
      chk("t4_grants", grant_log.size(), 4);
      if (grant_log.size() == 4) begin
         chk("t4_g0", grant_log[0], 0);
         chk("t4_g1", grant_log[1], 2);
         chk("t4_g2", grant_log[2], 3);
         chk("t4_g3", grant_log[3], 0);
      end

      // reset with both stages full
      clear_logs();
      drive(1'b0, 4'b1111, 8'h11, 8'h22, 8'h33, 8'h44);
      drive(1'b0, 4'b1111, 8'h11, 8'h22, 8'h33, 8'h44);
      drive(1'b1, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
      drive(1'b0, 4'b1010, 8'h70, 8'h00, 8'h10, 8'h00);
      @(negedge clk);
      chk("t5_rsp_after_rst", int'(bus_if.rsp_valid), 0);
      chk("t5_busy_after_rst", int'(bus_if.busy), 0);
      drive(1'b0, 4'b1000, 8'h70, 8'h00, 8'h00, 8'h00);
      idle(5);
      chk("t5_grants", grant_log.size(), 4);
      if (grant_log.size() == 4) begin
         chk("t5_post_rst_first", grant_log[2], 1);
         chk("t5_post_rst_second", grant_log[3], 3);
      end
      chk("t5_rsps", rsp_idx_log.size(), 3);
      if (rsp_idx_log.size() == 3) begin
         chk("t5_rsp0", rsp_idx_log[0], 1);
         chk("t5_rsp1", rsp_idx_log[1], 1);
         chk("t5_rsp2", rsp_idx_log[2], 3);
      end

      // requester 1 stalls three cycles holding 0x40
      clear_logs();
      drive(1'b0, 4'b0010, 8'h00, 8'h00, 8'h11, 8'h00);
      idle(1);
      for (int i = 0; i < 4; i++) drive(1'b0, 4'b1111, 8'h00, 8'h00, 8'h40, 8'h00);
      idle(5);
      chk("t6_grants", grant_log.size(), 5);
      if (grant_log.size() == 5) begin
         chk("t6_g1", grant_log[1], 2);
         chk("t6_g2", grant_log[2], 3);
         chk("t6_g3", grant_log[3], 0);
         chk("t6_g4", grant_log[4], 1);
      end
      for (int i = 0; i < rsp_idx_log.size(); i++) begin
         if (rsp_idx_log[i] == 1) tag1_res.push_back(rsp_res_log[i]);
      end
      chk("t6_tag1_count", tag1_res.size(), 2);
      if (tag1_res.size() == 2) begin
         chk("t6_first", tag1_res[0], 61);
         chk("t6_stalled", tag1_res[1], 122);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
